// File: rtl/matmul_compute.sv
// Streaming signed matrix multiply C = A x B, one dot product at a time, C emitted row-major on AXI-stream.
// Optional build macro MATMUL_RELU_EN clamps negative C elements to zero at output registration.
module matmul_compute #(
    parameter int INW  = 12,
    parameter int OUTW = 28,
    parameter int M    = 7,
    parameter int N    = 9,
    parameter int MAXK = 8,
    localparam int KW  = $clog2(MAXK + 1),
    localparam int AW  = $clog2(M * MAXK),
    localparam int BW  = $clog2(MAXK * N)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   matrices_loaded,
    input  logic [KW-1:0]          K,
    output logic [AW-1:0]          A_read_addr,
    output logic [BW-1:0]          B_read_addr,
    input  logic signed [INW-1:0]  A_data,
    input  logic signed [INW-1:0]  B_data,
    output logic                   compute_finished,
    output logic signed [OUTW-1:0] OUTPUT_TDATA,
    output logic                   OUTPUT_TVALID,
    input  logic                   OUTPUT_TREADY,
    output logic [2:0]             fsm_state
);
    localparam int MW = (M > 1) ? $clog2(M) : 1;
    localparam int NW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        DRAIN  = 3'd2,
        OUT    = 3'd3,
        FINISH = 3'd4,
        CLEAR  = 3'd5
    } state_t;

    state_t state, next_state;

    logic [KW-1:0]          k_lat;
    logic [KW-1:0]          k_idx;
    logic [MW-1:0]          m_idx;
    logic [NW-1:0]          n_idx;
    logic signed [OUTW-1:0] acc;
    logic signed [OUTW-1:0] tdata;

    logic signed [2*INW-1:0] prod;
    logic signed [OUTW-1:0]  prod_ext;
    logic signed [OUTW-1:0]  sum;
    logic signed [OUTW-1:0]  result;
    logic                    last_elem;
    logic                    fire;

    // Valid/ready: a C element moves only on a cycle where OUTPUT_TVALID and OUTPUT_TREADY
    // are both high; until then OUTPUT_TDATA and OUTPUT_TVALID are held unchanged.
    assign fire      = (state == OUT) && OUTPUT_TREADY;
    assign last_elem = (m_idx == MW'(M - 1)) && (n_idx == NW'(N - 1));

    assign prod     = A_data * B_data;
    assign prod_ext = {{(OUTW - 2*INW){prod[2*INW-1]}}, prod};
    assign sum      = acc + prod_ext;

`ifdef MATMUL_RELU_EN
    assign result = sum[OUTW-1] ? '0 : sum;
`else
    assign result = sum;
`endif

    assign A_read_addr = (state == ISSUE) ? (AW'(m_idx) * AW'(k_lat) + AW'(k_idx)) : '0;
    assign B_read_addr = (state == ISSUE) ? (BW'(k_idx) * BW'(N) + BW'(n_idx)) : '0;

    assign OUTPUT_TVALID    = (state == OUT);
    assign OUTPUT_TDATA     = tdata;
    assign compute_finished = (state == FINISH);
    assign fsm_state        = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:   if (matrices_loaded) next_state = (K == '0) ? OUT : ISSUE;
            ISSUE:  if (k_idx == k_lat - 1'b1) next_state = DRAIN;
            DRAIN:  next_state = OUT;
            OUT: begin
                if (OUTPUT_TREADY) begin
                    if (last_elem)          next_state = FINISH;
                    else if (k_lat == '0)   next_state = OUT;
                    else                    next_state = ISSUE;
                end
            end
            FINISH: next_state = CLEAR;
            CLEAR:  if (!matrices_loaded) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Read data lags its address by one cycle, so ISSUE accumulates the previous
    // pair from k=1 onward and DRAIN folds the final pair straight into the output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k_lat <= '0;
            k_idx <= '0;
            m_idx <= '0;
            n_idx <= '0;
            acc   <= '0;
            tdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (matrices_loaded) begin
                        k_lat <= K;
                        k_idx <= '0;
                        m_idx <= '0;
                        n_idx <= '0;
                        acc   <= '0;
                        tdata <= '0;
                    end
                end
                ISSUE: begin
                    k_idx <= k_idx + 1'b1;
                    if (k_idx != '0) acc <= sum;
                end
                DRAIN: tdata <= result;
                OUT: begin
                    if (fire) begin
                        acc   <= '0;
                        k_idx <= '0;
                        if (n_idx == NW'(N - 1)) begin
                            n_idx <= '0;
                            m_idx <= m_idx + 1'b1;
                        end else begin
                            n_idx <= n_idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_matmul_compute.sv
// Randomised self-checking bench for matmul_compute: C is predicted from plain nested-loop arithmetic.
module tb_matmul_compute;
    localparam int INW  = 12;
    localparam int OUTW = 28;
    localparam int M    = 2;
    localparam int N    = 2;
    localparam int MAXK = 8;
    localparam int KW   = $clog2(MAXK + 1);
    localparam int AW   = $clog2(M * MAXK);
    localparam int BW   = $clog2(MAXK * N);

    logic                   clk;
    logic                   reset;
    logic                   matrices_loaded;
    logic [KW-1:0]          k_in;
    logic [AW-1:0]          a_addr;
    logic [BW-1:0]          b_addr;
    logic signed [INW-1:0]  a_data;
    logic signed [INW-1:0]  b_data;
    logic                   finished;
    logic signed [OUTW-1:0] tdata;
    logic                   tvalid;
    logic                   tready;
    logic [2:0]             fsm_state;

    logic signed [INW-1:0] a_mem [M*MAXK];
    logic signed [INW-1:0] b_mem [MAXK*N];
    logic [OUTW-1:0]       exp_q [$];

    int n_vec = 0;
    int n_err = 0;

    matmul_compute #(.INW(INW), .OUTW(OUTW), .M(M), .N(N), .MAXK(MAXK)) dut (
        .clk              (clk),
        .reset            (reset),
        .matrices_loaded  (matrices_loaded),
        .K                (k_in),
        .A_read_addr      (a_addr),
        .B_read_addr      (b_addr),
        .A_data           (a_data),
        .B_data           (b_data),
        .compute_finished (finished),
        .OUTPUT_TDATA     (tdata),
        .OUTPUT_TVALID    (tvalid),
        .OUTPUT_TREADY    (tready),
        .fsm_state        (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous-read memories: data one cycle after the address
    always @(posedge clk) begin
        a_data <= a_mem[a_addr];
        b_data <= b_mem[b_addr];
    end

    function automatic logic [OUTW-1:0] relu_model(input longint s);
`ifdef MATMUL_RELU_EN
        if (s < 0) s = 0;
`endif
        return OUTW'(s);
    endfunction

    task automatic fill_random();
        logic [31:0] r;
        for (int i = 0; i < M*MAXK; i++) begin r = $urandom; a_mem[i] = r[INW-1:0]; end
        for (int i = 0; i < MAXK*N; i++) begin r = $urandom; b_mem[i] = r[INW-1:0]; end
    endtask

    task automatic build_model(input int kk);
        longint s;
        exp_q.delete();
        for (int m = 0; m < M; m++)
            for (int n = 0; n < N; n++) begin
                s = 0;
                for (int k = 0; k < kk; k++)
                    s += longint'(a_mem[m*kk+k]) * longint'(b_mem[k*N+n]);
                exp_q.push_back(relu_model(s));
            end
    endtask

    // Drives one full computation against exp_q; optional reset abort while element abort_at is valid.
    task automatic run_compute(input int kk, input int ready_pct, input int abort_at,
                               input bit release_reset, input string tag);
        int cyc = 0, transfers = 0, fin_count = 0, valid_due;
        bit waiting = 1'b1, held = 1'b0, rdy;
        logic [OUTW-1:0] held_data = '0, e;
        @(negedge clk);
        if (release_reset) reset = 1'b1;
        k_in = KW'(kk);
        matrices_loaded = 1'b1;
        tready = 1'b0;
        valid_due = (kk == 0) ? 1 : kk + 2;
        while (fin_count == 0 && cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (held) begin
                n_vec++;
                if (tvalid !== 1'b1 || tdata !== held_data) begin
                    n_err++;
                    $display("FAIL %s hold: tvalid=%b tdata=%0d required tvalid=1 tdata=%0d",
                             tag, tvalid, $signed(tdata), $signed(held_data));
                end
            end
            if (waiting && tvalid) begin
                waiting = 1'b0;
                n_vec++;
                if (cyc != valid_due) begin
                    n_err++;
                    $display("FAIL %s latency: tvalid at cycle %0d required %0d", tag, cyc, valid_due);
                end
            end
            if (finished) begin
                fin_count++;
                n_vec++;
                if (transfers != M*N) begin
                    n_err++;
                    $display("FAIL %s finish_count: transfers=%0d required %0d", tag, transfers, M*N);
                end
                break;
            end
            if (abort_at >= 0 && tvalid && transfers == abort_at) begin
                reset = 1'b0;
                #1;
                n_vec++;
                if (tvalid !== 1'b0 || finished !== 1'b0 || tdata !== '0 || a_addr !== '0 || b_addr !== '0) begin
                    n_err++;
                    $display("FAIL %s async_reset: tvalid=%b fin=%b tdata=%0d a=%0d b=%0d required all 0",
                             tag, tvalid, finished, $signed(tdata), a_addr, b_addr);
                end
                exp_q.delete();
                return;
            end
            rdy = ($urandom_range(99) < ready_pct);
            tready = rdy;
            if (tvalid && rdy) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL %s extra_transfer: tdata=%0d required no transfer", tag, $signed(tdata));
                end else begin
                    e = exp_q.pop_front();
                    if (tdata !== e) begin
                        n_err++;
                        $display("FAIL %s c[%0d]: got %0d required %0d", tag, transfers, $signed(tdata), $signed(e));
                    end
                end
                transfers++;
                held = 1'b0;
                waiting = 1'b1;
                valid_due = cyc + ((kk == 0) ? 1 : kk + 2);
            end else begin
                held = tvalid;
                held_data = tdata;
            end
        end
        tready = 1'b0;
        n_vec++;
        if (fin_count == 0) begin
            n_err++;
            $display("FAIL %s timeout: no compute_finished after %0d cycles, transfers=%0d", tag, cyc, transfers);
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s leftover: %0d elements not emitted, required 0", tag, exp_q.size());
        end
        // matrices_loaded stays high for a while: no second pulse, no second computation
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (finished !== 1'b0 || tvalid !== 1'b0) begin
                n_err++;
                $display("FAIL %s no_rerun: fin=%b tvalid=%b required 0 0", tag, finished, tvalid);
            end
        end
        matrices_loaded = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        matrices_loaded = 1'b0;
        tready = 1'b0;
        k_in = '0;
        for (int i = 0; i < M*MAXK; i++) a_mem[i] = '0;
        for (int i = 0; i < MAXK*N; i++) b_mem[i] = '0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (tvalid !== 1'b0 || finished !== 1'b0 || tdata !== '0 || a_addr !== '0 || b_addr !== '0) begin
            n_err++;
            $display("FAIL reset_state: tvalid=%b fin=%b tdata=%0d a=%0d b=%0d required all 0",
                     tvalid, finished, $signed(tdata), a_addr, b_addr);
        end
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_vec++;
            if (tvalid !== 1'b0 || finished !== 1'b0) begin
                n_err++;
                $display("FAIL idle_wait: tvalid=%b fin=%b required 0 0", tvalid, finished);
            end
        end
    endtask

    task automatic test_spec_example();
        a_mem[0] = 1; a_mem[1] = 2; a_mem[2] = 3; a_mem[3] = 4;
        b_mem[0] = 5; b_mem[1] = 6; b_mem[2] = 7; b_mem[3] = 8;
        exp_q.delete();
        exp_q.push_back(19); exp_q.push_back(22); exp_q.push_back(43); exp_q.push_back(50);
        run_compute(2, 100, -1, 1'b0, "example");
    endtask

    task automatic test_extremes();
        for (int i = 0; i < M*MAXK; i++) a_mem[i] = -12'sd2048;
        for (int i = 0; i < MAXK*N; i++) b_mem[i] = 12'sd2047;
        exp_q.delete();
        for (int i = 0; i < M*N; i++) begin
`ifdef MATMUL_RELU_EN
            exp_q.push_back('0);
`else
            exp_q.push_back(OUTW'(-33538048));
`endif
        end
        run_compute(MAXK, 100, -1, 1'b0, "extremes");
    endtask

    task automatic test_k_zero();
        fill_random();
        exp_q.delete();
        for (int i = 0; i < M*N; i++) exp_q.push_back('0);
        run_compute(0, 100, -1, 1'b0, "k_zero");
        fill_random();
        exp_q.delete();
        for (int i = 0; i < M*N; i++) exp_q.push_back('0);
        run_compute(0, 30, -1, 1'b0, "k_zero_stall");
    endtask

    task automatic test_random_backpressure();
        int kk;
        for (int it = 0; it < 6; it++) begin
            kk = $urandom_range(MAXK, 1);
            fill_random();
            build_model(kk);
            run_compute(kk, 30, -1, 1'b0, "random");
        end
    endtask

    task automatic test_back_to_back();
        for (int kk = 1; kk <= 3; kk++) begin
            fill_random();
            build_model(kk);
            run_compute(kk, 100, -1, 1'b0, "back_to_back");
        end
    endtask

    task automatic test_reset_mid_run();
        fill_random();
        build_model(3);
        run_compute(3, 100, 2, 1'b0, "abort");
        build_model(3);
        run_compute(3, 100, -1, 1'b1, "restart");
    endtask

    initial begin
        test_reset();
        test_spec_example();
        test_extremes();
        test_k_zero();
        test_random_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
